// File: rtl/counter_ud_mod.sv
// Up/down counter with programmable modulus, variable step, wrap or saturate handling and event pulses.
// Define COUNTER_UD_MOD_WRAPCNT_EN to build the wrap-event counter; otherwise wrap_cnt is tied to 0.
module counter_ud_mod #(
   parameter int WIDTH     = 8,
   parameter int MAX_VAL   = 2**WIDTH-1,
   parameter int STEP_W    = 4,
   parameter int WRAPCNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 load_en,
   input  logic [WIDTH-1:0]     load,
   input  logic                 down,
   input  logic [STEP_W-1:0]    step,
   input  logic                 sat_mode,
   output logic [WIDTH-1:0]     count,
   output logic                 at_max,
   output logic                 at_min,
   output logic                 wrap,
   output logic                 sat,
   output logic [WRAPCNT_W-1:0] wrap_cnt
);

   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + 1'b1;
   localparam logic [WIDTH-1:0] MAX_CNT = MAX_EXT[WIDTH-1:0];

   // A step larger than the modulus would need more than one correction per update.
   if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_max
      $error("counter_ud_mod: MAX_VAL out of range");
   end
   if (2**STEP_W-1 > MAX_VAL+1) begin : g_bad_step
      $error("counter_ud_mod: STEP_W too wide for MAX_VAL");
   end

   logic [WIDTH:0] count_ext;
   logic [WIDTH:0] step_ext;
   logic [WIDTH:0] next_ext;
   logic           next_wrap;
   logic           next_sat;

   assign count_ext = {1'b0, count};
   assign step_ext  = (WIDTH+1)'(step);

   // Next value of an enabled, non-zero step, evaluated one bit wider than the count.
   always_comb begin
      next_ext  = count_ext;
      next_wrap = 1'b0;
      next_sat  = 1'b0;
      if (!down) begin
         if (count_ext + step_ext <= MAX_EXT) begin
            next_ext = count_ext + step_ext;
         end else if (sat_mode) begin
            next_ext = MAX_EXT;
            next_sat = 1'b1;
         end else begin
            next_ext  = count_ext + step_ext - MOD_EXT;
            next_wrap = 1'b1;
         end
      end else begin
         if (step_ext <= count_ext) begin
            next_ext = count_ext - step_ext;
         end else if (sat_mode) begin
            next_ext = '0;
            next_sat = 1'b1;
         end else begin
            next_ext  = count_ext + MOD_EXT - step_ext;
            next_wrap = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else if (load_en) begin
         count <= (load > MAX_CNT) ? MAX_CNT : load;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else if (en && step != '0) begin
         count <= next_ext[WIDTH-1:0];
         wrap  <= next_wrap;
         sat   <= next_sat;
      end else begin
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end
   end

   assign at_max = (count == MAX_CNT);
   assign at_min = (count == '0);

`ifdef COUNTER_UD_MOD_WRAPCNT_EN
   // Counts wrap events and sticks at all-ones rather than rolling over.
   always_ff @(posedge clk) begin
      if (rst || load_en) begin
         wrap_cnt <= '0;
      end else if (en && step != '0 && next_wrap && wrap_cnt != '1) begin
         wrap_cnt <= wrap_cnt + 1'b1;
      end
   end
`else
   assign wrap_cnt = '0;
`endif

endmodule
